// File: rtl/link_led_decoder.sv
// Receiver-side status decoder: synchronises an asynchronous parallel code,
// filters it for stability and drives an LED pattern with blink/error handling.
module link_led_decoder #(
  parameter int unsigned CODE_W      = 4,
  parameter int unsigned LED_N       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned BLINK_EN    = 1,
  parameter int unsigned BLINK_HALF  = 25_000_000,
  parameter int unsigned ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] data_in,
  input  logic              clr_err,
  output logic [LED_N-1:0]  led,
  output logic [CODE_W-1:0] code_q,
  output logic              code_strobe,
  output logic [1:0]        mode,
  output logic              err_sticky,
  output logic [7:0]        change_cnt
);

  localparam int unsigned       CNT_W     = $clog2(STABLE_CYC + 1);
  localparam int unsigned       BLK_W     = $clog2(BLINK_HALF + 1);
  localparam logic [CODE_W-1:0] IDLE_CODE = '1;
  localparam logic [CODE_W-1:0] ALL_CODE  = {{(CODE_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ONE  = 2'd1,
    ST_ALL  = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  logic [CODE_W-1:0] sync_q [SYNC_STAGES];
  logic [CODE_W-1:0] sync_out;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] acc_q, acc_d;
  logic              strobe_q, strobe_d;
  logic [7:0]        chg_q, chg_d;
  logic              accept;
  state_e            state_q, state_d;
  logic [LED_N-1:0]  pat_q, pat_d;
  logic [BLK_W-1:0]  blink_q, blink_d;
  logic              err_q, err_d;

  // Plain flop chain; only the reset mux sits in front of each stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= IDLE_CODE;
    end else begin
      sync_q[0] <= data_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    accept = 1'b0;
    if (sync_out != cand_q) begin
      cand_d = sync_out;
      cnt_d  = '0;
    end else begin
      if (cnt_q != CNT_W'(STABLE_CYC)) cnt_d = cnt_q + CNT_W'(1);
      accept = (cnt_q == CNT_W'(STABLE_CYC - 1)) && (cand_q != acc_q);
    end
    acc_d    = accept ? cand_q : acc_q;
    strobe_d = accept;
    chg_d    = accept ? chg_q + 8'd1 : chg_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q   <= IDLE_CODE;
      cnt_q    <= '0;
      acc_q    <= IDLE_CODE;
      strobe_q <= 1'b0;
      chg_q    <= '0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      strobe_q <= strobe_d;
      chg_q    <= chg_d;
    end
  end

  // Special codes take priority over the one-hot range when LED_N overlaps them.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    blink_d = blink_q;
    err_d   = err_q & ~clr_err;
    if (strobe_q) begin
      if (acc_q == IDLE_CODE) begin
        state_d = ST_IDLE;
        pat_d   = '0;
      end else if (acc_q == ALL_CODE) begin
        state_d = ST_ALL;
        pat_d   = '1;
        blink_d = '0;
      end else if (32'(acc_q) < LED_N) begin
        state_d = ST_ONE;
        pat_d   = LED_N'(1) << acc_q;
      end else begin
        state_d = ST_ERR;
        err_d   = 1'b1;
      end
    end else if (state_q == ST_ALL && BLINK_EN != 0) begin
      if (blink_q == BLK_W'(BLINK_HALF - 1)) begin
        blink_d = '0;
        pat_d   = ~pat_q;
      end else begin
        blink_d = blink_q + BLK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      blink_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      blink_q <= blink_d;
      err_q   <= err_d;
    end
  end

  assign led         = (ACTIVE_LOW != 0) ? ~pat_q : pat_q;
  assign code_q      = acc_q;
  assign code_strobe = strobe_q;
  assign mode        = state_q;
  assign err_sticky  = err_q;
  assign change_cnt  = chg_q;

endmodule

// File: doc/link_led_decoder.md
Name: link_led_decoder

Overview:
- Receiver-side block on the secondary board: samples a parallel status code driven asynchronously by the master board, synchronises and glitch-filters it, and decodes it into an LED pattern.
- Successor of the fixed 4-bit/16-LED decoder. Adds parametrised width and LED count, a stability filter, a blink mode for the all-on code, invalid-code detection, selectable output polarity, and status outputs for debug.

Parameters:
- CODE_W, 4, width of the incoming code; minimum 2.
- LED_N, 16, number of LEDs; must be ≤ 2^CODE_W−2.
- SYNC_STAGES, 2, synchroniser flops; minimum 2.
- STABLE_CYC, 4, consecutive identical synchronised samples needed to accept a code; minimum 1.
- BLINK_EN, 1, 1 = ALL code blinks; 0 = ALL code is steady on.
- BLINK_HALF, 25_000_000, cycles per blink half-period; minimum 1.
- ACTIVE_LOW, 1, 1 = LED lit when its led bit is 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- data_in  in  CODE_W  raw code from the master board, asynchronous to clk.
- clr_err  in  1  synchronous clear of err_sticky.
- led  out  LED_N  physical LED drive.
- code_q  out  CODE_W  last accepted code.
- code_strobe  out  1  one-cycle pulse when code_q changes.
- mode  out  2  current state: 0 IDLE, 1 ONE, 2 ALL, 3 ERR.
- err_sticky  out  1  set when an invalid code is accepted.
- change_cnt  out  8  count of accepted code changes; wraps 255→0.

Behaviour:
- Special codes: IDLE_CODE = 2^CODE_W−1; ALL_CODE = 2^CODE_W−2. Codes 0..LED_N−1 are valid one-hot codes. All other codes are invalid.
- Reset (clears everything, including mid-operation):
  - sync chain, filter candidate, code_q = IDLE_CODE; filter counter = 0.
  - mode = IDLE; code_strobe = 0; err_sticky = 0; change_cnt = 0; blink counter = 0.
  - Internal pattern = all off, so led = {LED_N{ACTIVE_LOW}}.
- Synchroniser: SYNC_STAGES-deep flop chain on data_in. No other logic is placed between these flops.
- Filter:
  - Holds a candidate register and a counter.
  - If the sync output differs from the candidate: load the candidate, clear the counter.
  - Otherwise the counter increments, saturating at STABLE_CYC.
  - A code is accepted when the counter reaches STABLE_CYC−1 with sync output equal to the candidate, and the candidate differs from code_q.
  - On acceptance: code_q loads the candidate, code_strobe = 1 for exactly one cycle, change_cnt += 1.
  - Required latency: if data_in is stable from clock edge k, code_q updates at edge k+SYNC_STAGES+STABLE_CYC.
  - Any pulse shorter than STABLE_CYC cycles at the sync output is never accepted.
  - Re-presenting the current code_q value produces no strobe and no count.
- State machine: evaluated on the cycle code_strobe = 1; mode and led are registered one cycle after code_q.
  - IDLE_CODE → IDLE: pattern all off.
  - ALL_CODE → ALL: pattern all on. If BLINK_EN, the blink counter clears on entry; the pattern starts on and toggles every BLINK_HALF cycles while in ALL.
  - Valid code c → ONE: only bit c lit.
  - Invalid code → ERR: err_sticky set; pattern holds its previous value. A blink in progress freezes at its current phase.
- Any state goes to any other state on the next accepted code. ALL → ALL re-entry cannot occur, because an identical code is never re-accepted.
- Polarity: led = ACTIVE_LOW ? ~pattern : pattern.
- err_sticky:
  - Cleared by clr_err.
  - If clr_err and a set occur in the same cycle, set wins.
- change_cnt: 8 bits, wraps modulo 256, no saturation.

Test Plan:
- Reset, data_in = 4'hF held → after reset, led = 16'hFFFF, mode = 0, code_q = 15, no code_strobe, change_cnt = 0.
- data_in 15→5 at edge k (defaults) → code_strobe only at edge k+6; led = 16'hFFDF at k+7; mode = 1; change_cnt = 1.
- data_in 5→9 for 3 cycles then back to 5 → no strobe; code_q stays 5; led unchanged.
- data_in = 14, BLINK_HALF = 4 (test override) → mode = 2. led = 16'h0000 for 4 cycles, then 16'hFFFF for 4, then repeats. With BLINK_EN = 0, led stays 16'h0000.
- LED_N = 12, data_in = 13 → mode = 3, err_sticky = 1, led holds previous pattern. clr_err pulse in the same cycle as a second invalid acceptance → err_sticky remains 1.
- Toggle data_in between 3 and 4 (each held 10 cycles) 256 times → change_cnt wraps to 0. Assert rst mid-filter → all outputs return to reset values the next cycle.
